// File: rtl/barrel_shift_right_pipe.sv
// barrel_shift_right_pipe
// Pipelined 16-bit right barrel shifter, the partner of the combinational left shifter.
// One mux stage per shift-amount bit (8, 4, 2, 1 for 16 bits), each stage registered.
// The word is captured into stage 1 already shifted by the MSB control bit, so a
// word offered in cycle i is presented at the output in cycle i+SHW.
// Valid/ready on both sides; the whole pipe freezes when the output is stalled.
// Build option: define BSR_ROTATE_EN to make every stage rotate instead of
// shifting with zero fill. Ports, latency and handshake are identical in both builds.
module barrel_shift_right_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_ctrl,
    output logic             busy
);

    logic [SHW-1:0][WIDTH-1:0] st_data;
    logic [SHW-1:0][WIDTH-1:0] nx_data;
    logic [SHW-1:0][SHW-1:0]   st_ctrl;
    logic [SHW-1:0][SHW-1:0]   nx_ctrl;
    logic [SHW-1:0]            st_valid;
    logic [SHW-1:0]            nx_valid;
    logic                      stall;
    logic                      advance;

    // A held result at the output freezes every stage; flush also blocks intake.
    assign stall    = st_valid[SHW-1] & ~out_ready;
    assign advance  = ~stall;
    assign in_ready = ~stall & ~flush;

    // Valid bits move one stage per advance; a bubble enters when nothing is accepted.
    assign nx_valid = {st_valid[SHW-2:0], in_valid & in_ready};

    // Stage g handles control bit SHW-1-g, i.e. the largest shift comes first.
    for (genvar g = 0; g < SHW; g++) begin : g_stage
        localparam int AMT = 1 << (SHW - 1 - g);
        logic [WIDTH-1:0] src_data;
        logic [SHW-1:0]   src_ctrl;
        logic [WIDTH-1:0] shifted;

        if (g == 0) begin : g_first
            assign src_data = in_data;
            assign src_ctrl = in_ctrl;
        end else begin : g_next
            assign src_data = st_data[g-1];
            assign src_ctrl = st_ctrl[g-1];
        end

`ifdef BSR_ROTATE_EN
        assign shifted = {src_data[AMT-1:0], src_data[WIDTH-1:AMT]};
`else
        assign shifted = {{AMT{1'b0}}, src_data[WIDTH-1:AMT]};
`endif

        assign nx_data[g] = src_ctrl[SHW-1-g] ? shifted : src_data;
        assign nx_ctrl[g] = src_ctrl;
    end

    // Stage valid bits: flush wins over advancing, stall holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_valid <= '0;
        end else if (flush) begin
            st_valid <= '0;
        end else if (advance) begin
            st_valid <= nx_valid;
        end
    end

    // Stage data and shift amounts; held during stall so the output stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_data <= '0;
            st_ctrl <= '0;
        end else if (advance && !flush) begin
            st_data <= nx_data;
            st_ctrl <= nx_ctrl;
        end
    end

    assign out_valid = st_valid[SHW-1];
    assign out_data  = st_data[SHW-1];
    assign out_ctrl  = st_ctrl[SHW-1];
    assign busy      = |st_valid;

endmodule

// File: tb/tb_barrel_shift_right_pipe.sv
// Bench for barrel_shift_right_pipe: directed scenarios plus a random stream,
// with a queue-based scoreboard checked by an independent output monitor.
module tb_barrel_shift_right_pipe;

    localparam int WIDTH = 16;
    localparam int SHW   = 4;
    localparam int LAT   = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_ctrl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SHW-1:0]   out_ctrl;
    logic             busy;

    barrel_shift_right_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [SHW-1:0]   c;
        int               t;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   negcnt = 0;
    int   n_acc = 0;
    int   n_emit = 0;
    bit   chk_lat = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: right shift (or rotate) of a 16-bit word by n places.
    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] d, input int n);
        logic [2*WIDTH-1:0] dd;
`ifdef BSR_ROTATE_EN
        dd = {d, d} >> n;
`else
        dd = {{WIDTH{1'b0}}, d} >> n;
`endif
        return dd[WIDTH-1:0];
    endfunction

    // Monitor: handshakes resolved at the coming edge are observed mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        negcnt++;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_emit++;
                if (sb.size() == 0) begin
                    chk("unexpected_out", {16'h0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", {16'h0, out_data}, {16'h0, e.d});
                    chk("out_ctrl", {28'h0, out_ctrl}, {28'h0, e.c});
                    if (chk_lat) chk("latency", negcnt - e.t, LAT);
                end
            end
            if (flush) sb.delete();
            if (in_valid && in_ready) begin
                n_acc++;
                e.d = model(in_data, int'(in_ctrl));
                e.c = in_ctrl;
                e.t = negcnt;
                sb.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and keep it on the bus until it is accepted.
    task automatic offer(input logic [WIDTH-1:0] d, input logic [SHW-1:0] c);
        bit acc;
        int guard;
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        guard    = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            step();
            guard++;
        end while (!acc && guard < 50);
        if (!acc) chk("offer_timeout", 0, 1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        idle();
        out_ready = 1'b1;
        for (k = 0; k < 60; k++) begin
            if (sb.size() == 0 && !busy) break;
            step();
        end
        chk(name, (sb.size() == 0 && !busy) ? 1 : 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int acc0;
        int em0;
        int ir_bad;
        bit held_seen;
        bit held_bad;
        logic [WIDTH-1:0] held;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_data = '0; in_ctrl = '0; out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {31'h0, out_valid}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_out_data", {16'h0, out_data}, 0);
        chk("rst_out_ctrl", {28'h0, out_ctrl}, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("ready_after_rst", {31'h0, in_ready}, 1);
        step();

        // 1. Sweep 8000 >> 0..15, back to back, fixed latency
        chk_lat = 1;
        for (int n = 0; n < 16; n++) offer(16'h8000, SHW'(n));
        drain("sweep_drain");
        chk_lat = 0;

        // 2. Drop vs rotate
        offer(16'h0001, 4'd1);
        offer(16'hA5C3, 4'd4);
        offer(16'hFFFF, 4'd15);
        offer(16'h1357, 4'd0);
        drain("drop_drain");

        // 3. Backpressure
        out_ready = 1'b0;
        idx = 0; held_seen = 0; held_bad = 0; held = '0;
        for (int k = 0; k < 10; k++) begin
            in_valid = (idx < 6);
            in_data  = 16'hFFFF;
            in_ctrl  = SHW'(idx);
            @(negedge clk);
            if (out_valid) begin
                if (!held_seen) begin held = out_data; held_seen = 1; end
                else if (out_data !== held) held_bad = 1;
            end
            if (in_valid && in_ready) idx++;
            step();
        end
        chk("bp_accepts", idx, 4);
        chk("bp_head", {16'h0, held}, 32'h0000_FFFF);
        chk("bp_hold", {31'h0, held_bad}, 0);
        chk("bp_stall_ready", {31'h0, in_ready}, 0);
        out_ready = 1'b1;
        while (idx < 6) begin
            offer(16'hFFFF, SHW'(idx));
            idx++;
        end
        drain("bp_drain");

        // 4. Flush with three words in flight
        for (int k = 0; k < 3; k++) offer(16'($urandom), SHW'($urandom_range(0, 15)));
        acc0 = n_acc;
        flush = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF; in_ctrl = 4'd3;
        @(negedge clk);
        chk("flush_in_ready", {31'h0, in_ready}, 0);
        step();
        flush = 1'b0; idle();
        @(negedge clk);
        chk("flush_busy", {31'h0, busy}, 0);
        chk("flush_out_valid", {31'h0, out_valid}, 0);
        for (int k = 0; k < 8; k++) step();
        chk("flush_no_accept", n_acc - acc0, 0);

        // 5. Reset mid-stream
        for (int k = 0; k < 4; k++) offer(16'($urandom), SHW'($urandom_range(0, 15)));
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", {31'h0, out_valid}, 0);
        chk("rstmid_busy", {31'h0, busy}, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rstmid_ready", {31'h0, in_ready}, 1);
        step();
        chk_lat = 1;
        offer(16'h1234, 4'd8);
        drain("rstmid_drain");
        chk_lat = 0;

        // 6. Full-pipe swap
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_data = 16'($urandom); in_ctrl = SHW'($urandom_range(0, 15));
            step();
        end
        chk("swap_full", {31'h0, out_valid}, 1);
        out_ready = 1'b1;
        acc0 = n_acc; em0 = n_emit; ir_bad = 0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; in_data = 16'($urandom); in_ctrl = SHW'($urandom_range(0, 15));
            @(negedge clk);
            if (!in_ready) ir_bad++;
            step();
        end
        idle();
        chk("swap_accepts", n_acc - acc0, 8);
        chk("swap_emits", n_emit - em0, 8);
        chk("swap_ready", ir_bad, 0);
        drain("swap_drain");

        // 7. Random traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            in_ctrl   = SHW'($urandom_range(0, 15));
            step();
        end
        drain("rand_drain");

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
